// File: rtl/cal_pulse_pkg.sv
// Shared types and defaults for the calibration-pulse sequencer.
//   cal_seq_state_t : sequencer FSM state encoding
//   DefaultCntW     : default width of the width/delay/gap counters
//   DefaultNpW      : default width of the pulse-count fields
package cal_pulse_pkg;

   localparam int unsigned DefaultCntW = 32;
   localparam int unsigned DefaultNpW  = 16;

   typedef enum logic [2:0] {
      StIdle,
      StPulse,
      StDelay,
      StTrig,
      StWaitRo,
      StGap,
      StDone
   } cal_seq_state_t;

endpackage

// File: rtl/cal_pulse_timer.sv
// Loadable down-counter shared by the PULSE, DELAY and GAP phases.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   load_i      : load load_val_i this cycle (takes priority over counting)
//   load_val_i  : phase length minus one
//   expired_o   : counter has reached zero, i.e. current cycle is the phase's last
module cal_pulse_timer
   import cal_pulse_pkg::*;
#(
   parameter int unsigned CNT_W = DefaultCntW
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cal_pulse_sequencer.sv
// Calibration-pulse train sequencer.
// Ports:
//   ACLK, ARESET  : clock and asynchronous active-high reset
//   start, abort  : one-cycle requests from the register bank
//   n_pulses      : train length, 0 = run until abort
//   pulse_width   : cal_pulse high time (0 behaves as 1)
//   trig_delay    : cycles from cal_pulse fall to trig_out
//   gap_len       : idle cycles after readout release before the next pulse
//   readout_busy  : readout chain busy level
//   cal_pulse     : registered calibration pulse
//   trig_out      : registered one-cycle readout trigger
//   busy          : high in every non-idle state
//   done, aborted : one-cycle completion / abort strobes
//   pulses_sent   : triggers issued in the current or last train
module cal_pulse_sequencer
   import cal_pulse_pkg::*;
#(
   parameter int unsigned CNT_W = DefaultCntW,
   parameter int unsigned NP_W  = DefaultNpW
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             start,
   input  logic             abort,
   input  logic [NP_W-1:0]  n_pulses,
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [CNT_W-1:0] trig_delay,
   input  logic [CNT_W-1:0] gap_len,
   input  logic             readout_busy,
   output logic             cal_pulse,
   output logic             trig_out,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [NP_W-1:0]  pulses_sent
);

   cal_seq_state_t   state_q, state_d;
   logic [NP_W-1:0]  n_q, pulses_sent_q;
   logic [CNT_W-1:0] w_q, d_q, g_q;
   logic [CNT_W-1:0] pw_in;
   logic             cal_pulse_q, trig_q, busy_q, done_q, aborted_q;
   logic             tmr_load, tmr_expired, last_pulse;
   logic [CNT_W-1:0] tmr_val;

   // Zero width is promoted to one cycle before it is latched.
   assign pw_in      = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
   assign last_pulse = (pulses_sent_q == n_q) && (n_q != '0);

   cal_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i      (ACLK),
      .rst_i      (ARESET),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_expired)
   );

   // Timer is loaded with (length - 1) on every entry into a timed phase.
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StPulse;
               tmr_load = 1'b1;
               tmr_val  = pw_in - CNT_W'(1);
            end
         end
         StPulse: begin
            if (tmr_expired) begin
               if (d_q == '0) begin
                  state_d = StTrig;
               end else begin
                  state_d  = StDelay;
                  tmr_load = 1'b1;
                  tmr_val  = d_q - CNT_W'(1);
               end
            end
         end
         StDelay: begin
            if (tmr_expired) state_d = StTrig;
         end
         StTrig: begin
            state_d = StWaitRo;
         end
         StWaitRo: begin
            if (!readout_busy) begin
               if (last_pulse) begin
                  state_d = StDone;
               end else if (g_q == '0) begin
                  state_d  = StPulse;
                  tmr_load = 1'b1;
                  tmr_val  = w_q - CNT_W'(1);
               end else begin
                  state_d  = StGap;
                  tmr_load = 1'b1;
                  tmr_val  = g_q - CNT_W'(1);
               end
            end
         end
         StGap: begin
            if (tmr_expired) begin
               state_d  = StPulse;
               tmr_load = 1'b1;
               tmr_val  = w_q - CNT_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Abort overrides any exit decided above.
      if (abort && (state_q != StIdle)) state_d = StIdle;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q       <= StIdle;
         n_q           <= '0;
         w_q           <= CNT_W'(1);
         d_q           <= '0;
         g_q           <= '0;
         pulses_sent_q <= '0;
         cal_pulse_q   <= 1'b0;
         trig_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == StIdle) && start) begin
            n_q           <= n_pulses;
            w_q           <= pw_in;
            d_q           <= trig_delay;
            g_q           <= gap_len;
            pulses_sent_q <= '0;
         end else if (state_d == StTrig) begin
            // Counted on TRIG entry so it moves together with trig_out.
            pulses_sent_q <= pulses_sent_q + NP_W'(1);
         end
         // Outputs are decoded from the next state so they are plain flops.
         cal_pulse_q <= (state_d == StPulse);
         trig_q      <= (state_d == StTrig);
         busy_q      <= (state_d != StIdle);
         done_q      <= (state_d == StDone);
         aborted_q   <= abort && (state_q != StIdle);
      end
   end

   assign cal_pulse   = cal_pulse_q;
   assign trig_out    = trig_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign aborted     = aborted_q;
   assign pulses_sent = pulses_sent_q;

endmodule

// File: tb/tb_cal_pulse_sequencer.sv
// Self-checking bench for cal_pulse_sequencer. Cycle numbers are relative to the
// cycle in which start is driven (cycle 0); outputs are sampled on the falling edge.
module tb_cal_pulse_sequencer;

   localparam int CNT_W = 32;
   localparam int NP_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, abort, readout_busy;
   logic [NP_W-1:0]  n_pulses;
   logic [CNT_W-1:0] pulse_width, trig_delay, gap_len;
   logic             cal_pulse, trig_out, busy, done, aborted;
   logic [NP_W-1:0]  pulses_sent;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int w, d, g, n;
      int ab;          // drive abort together with start
      int first_trig;  // cycle of the first trig_out
      int period;      // cycles between consecutive triggers
      int done_at;     // cycle of the done strobe
   } vec_t;

   vec_t vecs[6];
   int   trig_q[$];

   cal_pulse_sequencer #(
      .CNT_W (CNT_W),
      .NP_W  (NP_W)
   ) dut (
      .ACLK         (clk),
      .ARESET       (rst),
      .start        (start),
      .abort        (abort),
      .n_pulses     (n_pulses),
      .pulse_width  (pulse_width),
      .trig_delay   (trig_delay),
      .gap_len      (gap_len),
      .readout_busy (readout_busy),
      .cal_pulse    (cal_pulse),
      .trig_out     (trig_out),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .pulses_sent  (pulses_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic set_cfg(input int w, input int d, input int g, input int n);
      pulse_width = CNT_W'(w);
      trig_delay  = CNT_W'(d);
      gap_len     = CNT_W'(g);
      n_pulses    = NP_W'(n);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " cal_pulse"}, cal_pulse, 0);
      check({tag, " trig_out"}, trig_out, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " aborted"}, aborted, 0);
      check({tag, " pulses_sent"}, pulses_sent, 0);
   endtask

   // Runs one full train with readout idle; expected trigger cycles go to the scoreboard.
   task automatic run_vec(input vec_t v, input string tag);
      int done_cnt = 0, done_cyc = -1, hi_cnt = 0, busy_bad = 0, ab_cnt = 0;
      int wp = (v.w == 0) ? 1 : v.w;
      @(negedge clk);
      set_cfg(v.w, v.d, v.g, v.n);
      start = 1'b1;
      abort = (v.ab != 0);
      for (int i = 0; i < v.n; i++) trig_q.push_back(v.first_trig + i * v.period);
      for (int rel = 1; rel <= v.done_at + 2; rel++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (rel == 1) set_cfg(v.w + 7, v.d + 3, v.g + 5, v.n + 2); // must be ignored
         if (trig_out) begin
            if (trig_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL %s unexpected trig_out: actual cycle=%0d expected none", tag, rel);
            end else begin
               check({tag, " trig cycle"}, rel, trig_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = rel;
         end
         if (cal_pulse) hi_cnt++;
         if (aborted) ab_cnt++;
         if (busy != (rel <= v.done_at)) busy_bad++;
      end
      check({tag, " missing trigs"}, trig_q.size(), 0);
      trig_q.delete();
      check({tag, " done cycle"}, done_cyc, v.done_at);
      check({tag, " done count"}, done_cnt, 1);
      check({tag, " cal_pulse cycles"}, hi_cnt, v.n * wp);
      check({tag, " busy window errors"}, busy_bad, 0);
      check({tag, " aborted count"}, ab_cnt, 0);
      check({tag, " pulses_sent"}, pulses_sent, v.n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ntrig, per_bad, done_cnt, stall_bad, ab_cnt;

      //          w  d  g   n  ab first period done
      vecs[0] = '{4, 2, 10, 3, 0, 7,   18,   45};
      vecs[1] = '{0, 0, 0,  2, 0, 2,   3,    7};
      vecs[2] = '{1, 5, 0,  1, 0, 7,   0,    9};
      vecs[3] = '{3, 0, 2,  2, 0, 4,   7,    13};
      vecs[4] = '{2, 1, 1,  4, 0, 4,   6,    24};
      vecs[5] = '{2, 0, 0,  1, 1, 3,   0,    5};

      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      readout_busy = 1'b0;
      set_cfg(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;

      // abort while idle does nothing
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle abort aborted", aborted, 0);
      check("idle abort busy", busy, 0);

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // readout_busy held high for 20 cycles from the trigger: W=2 D=1 G=3 n=1, trig at 4.
      // busy is low for the edge ending cycle 24, so WAIT_RO exits there and DONE is cycle 25.
      @(negedge clk);
      set_cfg(2, 1, 3, 1);
      start = 1'b1;
      stall_bad = 0;
      done_cnt  = 0;
      for (int rel = 1; rel <= 26; rel++) begin
         @(negedge clk);
         start = 1'b0;
         if (rel == 4) begin
            check("ro trig", trig_out, 1);
            readout_busy = 1'b1;
         end
         if (rel == 24) readout_busy = 1'b0;
         if (rel >= 5 && rel <= 24 && (!busy || done || cal_pulse)) stall_bad++;
         if (done) done_cnt++;
         if (rel == 25) check("ro done cycle", done, 1);
         if (rel == 26) check("ro busy after done", busy, 0);
      end
      check("ro stall errors", stall_bad, 0);
      check("ro done count", done_cnt, 1);

      // continuous mode W=1 D=0 G=5: trig every 8 cycles from cycle 2; abort in GAP at 837
      @(negedge clk);
      set_cfg(1, 0, 5, 0);
      start = 1'b1;
      ntrig = 0;
      per_bad = 0;
      done_cnt = 0;
      for (int rel = 1; rel <= 837; rel++) begin
         @(negedge clk);
         start = 1'b0;
         if (trig_out) begin
            if (rel != 2 + 8 * ntrig) per_bad++;
            ntrig++;
         end
         if (done) done_cnt++;
      end
      check("cont trig count", ntrig, 105);
      check("cont trig spacing errors", per_bad, 0);
      check("cont pulses_sent", pulses_sent, 105);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("cont aborted", aborted, 1);
      check("cont busy after abort", busy, 0);
      check("cont pulses_sent held", pulses_sent, 105);
      check("cont done", done | done_cnt[0], 0);
      @(negedge clk);
      check("cont aborted one cycle", aborted, 0);
      check("cont pulses_sent still held", pulses_sent, 105);

      // abort during the second pulse (W=3 D=0 G=0 n=3: pulse 6..8) with a simultaneous start
      @(negedge clk);
      set_cfg(3, 0, 0, 3);
      start = 1'b1;
      for (int rel = 1; rel <= 7; rel++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("abp cal_pulse before abort", cal_pulse, 1);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("abp cal_pulse dropped", cal_pulse, 0);
      check("abp aborted", aborted, 1);
      check("abp busy", busy, 0);
      check("abp pulses_sent held", pulses_sent, 1);
      @(negedge clk);
      check("abp start ignored", busy, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abp restart busy", busy, 1);
      check("abp restart cal_pulse", cal_pulse, 1);
      check("abp restart pulses_sent", pulses_sent, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abp second abort", aborted, 1);

      // async reset in the second DELAY (W=1 D=8 G=0 n=2: delay 13..20)
      @(negedge clk);
      set_cfg(1, 8, 0, 2);
      start = 1'b1;
      for (int rel = 1; rel <= 15; rel++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("rst pre pulses_sent", pulses_sent, 1);
      check("rst pre busy", busy, 1);
      #2 rst = 1'b1;
      #1 check_quiet("async reset");
      @(negedge clk);
      rst = 1'b0;
      ab_cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (aborted) ab_cnt++;
      end
      check("rst no aborted strobe", ab_cnt, 0);
      run_vec(vecs[0], "post-reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
